// File: rtl/output_port_allocator_pkg.sv
// Shared sizes, FSM encodings and helpers for the per-output-port allocator.
package output_port_allocator_pkg;

    localparam int unsigned NUM_IN     = 7;
    localparam int unsigned CREDIT_MAX = 16;
    localparam int unsigned SELW       = 3;
    localparam int unsigned CNTW       = 5;
    localparam int unsigned STALLW     = 8;

    localparam logic [0:0] ALLOC_IDLE   = 1'b0;
    localparam logic [0:0] ALLOC_LOCKED = 1'b1;

    // Round-robin successor of an input index, wrapping NUM_IN-1 -> 0.
    function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] i);
        return (i == SELW'(NUM_IN - 1)) ? '0 : i + SELW'(1);
    endfunction

endpackage

// File: rtl/output_port_allocator_if.sv
// Request/grant/credit bundle between the input units and one output-port allocator.
// credit_err exists only when OUT_ALLOC_CREDIT_ERR_EN is defined.
interface output_port_allocator_if;
    import output_port_allocator_pkg::*;

    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] tail;
    logic              credit_in;
    logic [NUM_IN-1:0] grant;
    logic              grant_valid;
    logic [SELW-1:0]   sel;
    logic [CNTW-1:0]   credits;
    logic              locked;
`ifdef OUT_ALLOC_CREDIT_ERR_EN
    logic              credit_err;

    modport master (output req, tail, credit_in,
                    input  grant, grant_valid, sel, credits, locked, credit_err);
    modport slave  (input  req, tail, credit_in,
                    output grant, grant_valid, sel, credits, locked, credit_err);
`else
    modport master (output req, tail, credit_in,
                    input  grant, grant_valid, sel, credits, locked);
    modport slave  (input  req, tail, credit_in,
                    output grant, grant_valid, sel, credits, locked);
`endif

endinterface

// File: rtl/output_port_allocator_rr_priority_arbiter.sv
// Combinational mask-based round-robin pick: lowest requester at or above ptr,
// otherwise lowest requester overall.
module rr_priority_arbiter #(
    parameter int unsigned NUM_IN = 7,
    parameter int unsigned SELW   = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SELW-1:0]   ptr,
    output logic [NUM_IN-1:0] gnt,
    output logic [SELW-1:0]   idx,
    output logic              any
);

    logic [NUM_IN-1:0] mask;
    logic [NUM_IN-1:0] masked;
    logic [NUM_IN-1:0] pick;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            mask[i] = (SELW'(i) >= ptr);
        end
        masked = req & mask;
        pick   = (|masked) ? masked : req;
        // isolate lowest set bit
        gnt    = pick & (~pick + NUM_IN'(1));
        idx    = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (gnt[i]) idx = SELW'(i);
        end
        any    = |req;
    end

endmodule

// File: rtl/output_port_allocator.sv
// Output-port allocator: round-robin, packet-locked, credit-gated grant to one of NUM_IN inputs.
// Optional OUT_ALLOC_CREDIT_ERR_EN adds a sticky credit_err (credit overflow / locked stall).
module output_port_allocator
    import output_port_allocator_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    output_port_allocator_if.slave  bus
);

    logic [0:0]        state, state_n;
    logic [SELW-1:0]   ptr, ptr_n;
    logic [SELW-1:0]   owner, owner_n;
    logic [CNTW-1:0]   cred, cred_n;

    logic [NUM_IN-1:0] arb_gnt;
    logic [SELW-1:0]   arb_idx;
    logic              arb_any;

    logic [NUM_IN-1:0] gnt_c;
    logic [SELW-1:0]   sel_c;
    logic              gv_c;

    rr_priority_arbiter #(.NUM_IN(NUM_IN), .SELW(SELW)) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Next-state, grant and credit arithmetic
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        gnt_c   = '0;
        sel_c   = '0;
        if (!rst && (cred != '0)) begin
            if (state == ALLOC_LOCKED) begin
                if (bus.req[owner]) begin
                    gnt_c = NUM_IN'(1) << owner;
                    sel_c = owner;
                    if (bus.tail[owner]) begin
                        state_n = ALLOC_IDLE;
                        ptr_n   = next_idx(owner);
                    end
                end
            end else if (arb_any) begin
                gnt_c = arb_gnt;
                sel_c = arb_idx;
                if (bus.tail[arb_idx]) begin
                    ptr_n = next_idx(arb_idx);
                end else begin
                    state_n = ALLOC_LOCKED;
                    owner_n = arb_idx;
                end
            end
        end
        gv_c = |gnt_c;
        cred_n = cred;
        if (bus.credit_in && !gv_c) begin
            cred_n = (cred == CNTW'(CREDIT_MAX)) ? cred : cred + CNTW'(1);
        end else if (!bus.credit_in && gv_c) begin
            cred_n = cred - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ALLOC_IDLE;
            ptr   <= '0;
            owner <= '0;
            cred  <= CNTW'(CREDIT_MAX);
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            cred  <= cred_n;
        end
    end

`ifdef OUT_ALLOC_CREDIT_ERR_EN
    logic [STALLW-1:0] stall, stall_n;
    logic              err, err_n;

    // Overflow credit or a locked port starved of its owner's flits for 256 cycles
    always_comb begin
        stall_n = '0;
        err_n   = err;
        if (bus.credit_in && !gv_c && (cred == CNTW'(CREDIT_MAX))) err_n = 1'b1;
        if ((state == ALLOC_LOCKED) && !gv_c) begin
            if (stall == {STALLW{1'b1}}) begin
                err_n   = 1'b1;
                stall_n = stall;
            end else begin
                stall_n = stall + STALLW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall <= '0;
            err   <= 1'b0;
        end else begin
            stall <= stall_n;
            err   <= err_n;
        end
    end

    assign bus.credit_err = err;
`endif

    assign bus.grant       = gnt_c;
    assign bus.grant_valid = gv_c;
    assign bus.sel         = sel_c;
    assign bus.credits     = rst ? CNTW'(CREDIT_MAX) : cred;
    assign bus.locked      = !rst && (state == ALLOC_LOCKED);

endmodule

// File: tb/tb_output_port_allocator.sv
// Self-checking bench for output_port_allocator: vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the allocation rules.
module tb_output_port_allocator;
    import output_port_allocator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    output_port_allocator_if bus();

    output_port_allocator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    int m_ptr   = 0;
    int m_owner = 0;
    int m_cred  = 16;
    int m_stall = 0;
    bit m_lock  = 1'b0;
    bit m_err   = 1'b0;

    // outputs sampled during the last step
    logic [NUM_IN-1:0] a_grant;
    logic [CNTW-1:0]   a_cred;
    logic              a_lock;

    typedef struct {
        logic [NUM_IN-1:0] req;
        logic [NUM_IN-1:0] tail;
        logic              cin;
        logic [NUM_IN-1:0] eg;
        int                ecr;
        logic              el;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, compare against the model before the edge, then advance the model.
    task automatic step(input logic [NUM_IN-1:0] r, input logic [NUM_IN-1:0] t,
                        input logic c, input logic rs);
        int win;
        bit g;
        logic [NUM_IN-1:0] eg;
        int es;
        bus.req = r;
        bus.tail = t;
        bus.credit_in = c;
        rst = rs;
        #4;
        win = -1;
        if (!rs) begin
            if (m_lock) begin
                if (r[m_owner]) win = m_owner;
            end else begin
                for (int k = 0; k < int'(NUM_IN); k++) begin
                    int idx;
                    idx = (m_ptr + k) % int'(NUM_IN);
                    if (r[idx] && win < 0) win = idx;
                end
            end
        end
        g  = (win >= 0) && (m_cred > 0);
        eg = g ? (NUM_IN'(1) << win) : '0;
        es = g ? win : 0;
        a_grant = bus.grant;
        a_cred  = bus.credits;
        a_lock  = bus.locked;
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("sel", 32'(bus.sel), es);
        chk("grant_valid", 32'(bus.grant_valid), 32'(g));
        chk("credits", 32'(bus.credits), rs ? 16 : m_cred);
        chk("locked", 32'(bus.locked), 32'(!rs && m_lock));
`ifdef OUT_ALLOC_CREDIT_ERR_EN
        if (!rs) chk("credit_err", 32'(bus.credit_err), 32'(m_err));
`endif
        @(posedge clk);
        if (rs) begin
            m_lock = 1'b0; m_ptr = 0; m_owner = 0; m_cred = 16; m_stall = 0; m_err = 1'b0;
        end else begin
            if (c && m_cred == 16 && !g) m_err = 1'b1;
            if (m_lock && !g) begin
                m_stall++;
                if (m_stall >= 256) m_err = 1'b1;
            end else begin
                m_stall = 0;
            end
            if (g) begin
                if (t[win]) begin
                    m_lock = 1'b0;
                    m_ptr  = (win + 1) % int'(NUM_IN);
                end else begin
                    m_lock  = 1'b1;
                    m_owner = win;
                end
            end
            m_cred = m_cred + int'(c) - int'(g);
            if (m_cred > 16) m_cred = 16;
        end
        #1;
    endtask

    initial begin
        int cnt;
        bus.req = '0;
        bus.tail = '0;
        bus.credit_in = 1'b0;

        tbl[0] = '{7'b0000101, 7'h7F, 1'b0, 7'b0000001, 16, 1'b0};
        tbl[1] = '{7'b0000101, 7'h7F, 1'b0, 7'b0000100, 15, 1'b0};
        tbl[2] = '{7'b0000101, 7'h7F, 1'b0, 7'b0000001, 14, 1'b0};
        tbl[3] = '{7'b0000101, 7'h7F, 1'b0, 7'b0000100, 13, 1'b0};
        tbl[4] = '{7'b0101000, 7'h00, 1'b0, 7'b0001000, 12, 1'b0};
        tbl[5] = '{7'b0101000, 7'h00, 1'b0, 7'b0001000, 11, 1'b1};
        tbl[6] = '{7'b0101000, 7'h00, 1'b0, 7'b0001000, 10, 1'b1};
        tbl[7] = '{7'b0101000, 7'h08, 1'b0, 7'b0001000,  9, 1'b1};
        tbl[8] = '{7'b0101000, 7'h7F, 1'b0, 7'b0100000,  8, 1'b0};

        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);

        // alternation and a locked 4-flit packet
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].req, tbl[i].tail, tbl[i].cin, 1'b0);
            chk("tbl_grant", 32'(a_grant), 32'(tbl[i].eg));
            chk("tbl_credits", 32'(a_cred), tbl[i].ecr);
            chk("tbl_locked", 32'(a_lock), 32'(tbl[i].el));
        end

        // credit exhaustion and single-credit refill
        step('0, '0, 1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(7'b0000010, 7'h7F, 1'b0, 1'b0);
            if (a_grant[1]) cnt++;
        end
        chk("exhaust_count", cnt, 16);
        chk("exhaust_credits", 32'(a_cred), 0);
        step(7'b0000010, 7'h7F, 1'b1, 1'b0);
        chk("starved_grant", 32'(a_grant), 0);
        step(7'b0000010, 7'h7F, 1'b0, 1'b0);
        chk("refill_grant", 32'(a_grant), 32'(7'b0000010));
        step(7'b0000010, 7'h7F, 1'b0, 1'b0);
        chk("refill_once", 32'(a_grant), 0);

        // simultaneous grant and credit return; saturation at full
        for (int i = 0; i < 5; i++) step('0, '0, 1'b1, 1'b0);
        step(7'b0000010, 7'h7F, 1'b1, 1'b0);
        chk("same_cycle_grant", 32'(a_grant), 32'(7'b0000010));
        step('0, '0, 1'b0, 1'b0);
        chk("same_cycle_credits", 32'(a_cred), 5);
        for (int i = 0; i < 11; i++) step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        chk("saturate_credits", 32'(a_cred), 16);
`ifdef OUT_ALLOC_CREDIT_ERR_EN
        chk("overflow_err", 32'(bus.credit_err), 1);
`endif

        // bubble while locked on input 4
        step(7'b0010000, 7'h00, 1'b0, 1'b0);
        chk("bubble_lock_grant", 32'(a_grant), 32'(7'b0010000));
        for (int i = 0; i < 3; i++) begin
            step(7'b0000001, 7'h00, 1'b0, 1'b0);
            chk("bubble_no_grant", 32'(a_grant), 0);
            chk("bubble_locked", 32'(a_lock), 1);
        end
        step(7'b0010001, 7'b0010000, 1'b0, 1'b0);
        chk("bubble_resume", 32'(a_grant), 32'(7'b0010000));

        // reset in the middle of a packet
        while (m_cred > 10) step(7'b0000100, 7'h7F, 1'b0, 1'b0);
        step(7'b0000100, 7'h00, 1'b0, 1'b0);
        chk("pre_rst_locked", 32'(bus.locked), 1);
        chk("pre_rst_credits", 32'(bus.credits), 9);
        step(7'b0000100, 7'h00, 1'b0, 1'b1);
        step(7'b1000000, 7'h7F, 1'b0, 1'b0);
        chk("post_rst_grant6", 32'(a_grant), 32'(7'b1000000));
        chk("post_rst_credits", 32'(a_cred), 16);
        chk("post_rst_locked", 32'(a_lock), 0);

        // wrap-around between indices 6 and 0
        for (int i = 0; i < 2; i++) begin
            step(7'b1000000, 7'h7F, 1'b0, 1'b0);
            chk("wrap_grant6", 32'(a_grant), 32'(7'b1000000));
            step(7'b0000001, 7'h7F, 1'b0, 1'b0);
            chk("wrap_grant0", 32'(a_grant), 32'(7'b0000001));
        end

`ifdef OUT_ALLOC_CREDIT_ERR_EN
        // owner stalls with the port held
        step('0, '0, 1'b0, 1'b1);
        step(7'b0000001, 7'h00, 1'b0, 1'b0);
        for (int i = 0; i < 255; i++) step('0, '0, 1'b0, 1'b0);
        chk("stall_err_before", 32'(bus.credit_err), 0);
        step('0, '0, 1'b0, 1'b0);
        chk("stall_err_after", 32'(bus.credit_err), 1);
`endif

        // randomized traffic against the model
        step('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            logic [NUM_IN-1:0] r;
            logic [NUM_IN-1:0] t;
            r = NUM_IN'($urandom & $urandom);
            t = NUM_IN'($urandom);
            step(r, t, ($urandom_range(0, 2) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
- Per-output-port allocator for the dynamic router.
- Shares one output port between NUM_IN input units using round-robin priority.
- Holds the port for the full duration of a multi-flit packet.
- Gates every grant on credits for the downstream input queue, which is IN_Q_SIZE deep.
- One instance per output port; sits between the input units' route-computation results and the crossbar select.

Parameters:
- NUM_IN, 7: number of requesting input units (6 torus directions + local).
- CREDIT_MAX, 16: downstream queue depth (IN_Q_SIZE); reset credit count.
- SELW, 3: width of sel; equals clog2(NUM_IN).
- CNTW, 5: credit counter width; equals clog2(CREDIT_MAX+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_IN  req[i]=1: input i has a flit at its queue head destined for this port
- tail  in  NUM_IN  tail[i]=1: input i's head flit is the last flit of its packet
- credit_in  in  1  one-cycle pulse; downstream dequeued one flit
- grant  out  NUM_IN  one-hot; grant[i]=1 means input i's head flit crosses the crossbar this cycle and input i dequeues it
- grant_valid  out  1  OR of grant
- sel  out  SELW  index of the granted input; crossbar select; 0 when no grant
- credits  out  CNTW  current downstream credit count
- locked  out  1  port held by a packet in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset state: state=IDLE, ptr=0, owner=0, credits=CREDIT_MAX.
- Outputs while rst=1: grant=0, grant_valid=0, sel=0, locked=0, credits=CREDIT_MAX.
- Reset mid-packet: drops the lock. Upstream flushing is not this block's concern.
- Grant path: grant/sel/grant_valid are combinational from current req/tail and registered state. Zero-cycle latency request to grant; one flit per cycle maximum.
- State updates on the clk edge.
- credits>0 is required for any grant. With credits==0, grant=0 in every state.
- FSM, IDLE:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1.
  - If a winner exists and credits>0: grant[winner]=1.
  - If tail[winner]=0: go to LOCKED with owner=winner.
  - Else stay IDLE and set ptr=(winner+1) mod NUM_IN.
- FSM, LOCKED:
  - Only owner is eligible; all other req are ignored.
  - If req[owner] and credits>0: grant[owner]=1.
  - If that flit has tail[owner]=1: go to IDLE and set ptr=(owner+1) mod NUM_IN.
  - If req[owner]=0: no grant and stay LOCKED (bubble).
- ptr is unchanged on cycles with no grant.
- locked=1 iff state==LOCKED.
- Credit arithmetic, per cycle:
  - credits += credit_in, credits -= grant_valid.
  - Both in the same cycle: unchanged.
  - credit_in while credits==CREDIT_MAX with no grant: ignored; credits saturate at CREDIT_MAX.
  - Decrement cannot underflow because a grant requires credits>0.
- Wrap-around: ptr wraps NUM_IN-1 → 0. A single requester at index NUM_IN-1 followed by index 0 alternates correctly.

Optional Feature:
- Macro: OUT_ALLOC_CREDIT_ERR_EN.
- Defined:
  - Adds output credit_err (1 bit), sticky, cleared only by rst.
  - Set when credit_in=1 and credits==CREDIT_MAX and grant_valid=0 (overflow).
  - Set when req[owner] falls with tail never seen and the port stays LOCKED for 256 consecutive cycles. An 8-bit stall counter is reset on every grant to owner.
- Not defined: no port, no counter; overflow credit silently ignored as above.

Decomposition:
- Shared include para.v holds NUM_PORTS (=7), IN_Q_SIZE, FLIT_SIZE, and the FSM state encodings (ALLOC_IDLE=1'b0, ALLOC_LOCKED=1'b1).
- One sub-module: rr_priority_arbiter. Combinational mask-based round-robin pick, parameterized NUM_IN; inputs req and ptr; outputs one-hot gnt and index.
- The FSM, credit counter and ptr register stay in output_port_allocator.

Test Plan:
- Reset, then req=7'b0000101, tail=all 1 for 4 cycles → grants alternate input0, input2, input0, input2; credits 16→12.
- Input3 sends a 4-flit packet (tail only on flit 4) while req[5] held high → grant[3] for 4 consecutive cycles, locked=1 through the 3rd; grant[5] in cycle 5; ptr=4 after packet.
- No credit_in, single requester input1 held, single-flit packets → exactly 16 grants, then grant=0 while credits==0. One credit_in pulse → exactly one more grant next cycle.
- Same-cycle grant and credit_in with credits=5 → credits stays 5. credit_in at credits=16 with no grant → stays 16; credit_err=1 if OUT_ALLOC_CREDIT_ERR_EN.
- Locked on input4 with req[4] dropped for 3 cycles, req[0] high → no grants during the bubble; input4 granted when req[4] returns.
- rst asserted mid-packet while LOCKED with credits=9 → next cycle locked=0, credits=16, ptr=0; req[6] granted immediately after rst deasserts.
